// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
//   Groups the receive-side stream inputs and status outputs of lfsr_checker.
//   master : drives enable / noise_in / clear, observes status
//   slave  : the checker itself
// Signals:
//   enable    stream strobe, noise_in valid when 1
//   noise_in  received serial noise bit
//   clear     synchronous clear of err_count / bit_count
//   locked    checker synchronised to the stream
//   error     one-cycle pulse on a mismatch while locked
//   err_count saturating mismatch count (locked only)
//   bit_count saturating checked-bit count (locked only, optional)
interface lfsr_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             enable;
  logic             noise_in;
  logic             clear;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output enable, noise_in, clear,
    input  locked, error, err_count, bit_count
  );

  modport slave (
    input  enable, noise_in, clear,
    output locked, error, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Self-synchronising checker for the x^16+x^15+x^14+x^11 Fibonacci noise
//   stream. Fills a 16-bit history from the line, verifies LOCK_COUNT
//   consecutive predictions, then free-runs on its own predictions so that a
//   single corrupted line bit produces a single error. LOSS_COUNT mismatches
//   inside one LOSS_WIN-bit window drop lock and restart the fill.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    lfsr_checker_if.slave (enable, noise_in, clear in;
//          locked, error, err_count, bit_count out)
// Optional feature macro: LFSR_CHK_BITCNT_EN
//   defined   -> bit_count counts checked bits while locked (saturating)
//   undefined -> no bit counter, bit_count tied to zero
module lfsr_checker #(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int LOSS_WIN   = 64,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  lfsr_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LIMIT = LW'(LOSS_COUNT);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WIN - 1);
  localparam logic [3:0]    FILL_LAST  = 4'd15;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next stream bit predicted from the history (hist[0] newest).
  function automatic logic pred_bit(input logic [15:0] h);
    return h[15] ^ h[14] ^ h[13] ^ h[10];
  endfunction

  // Increment that holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_W'(1);
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [15:0]      hist_r, hist_s;
  logic [3:0]       fill_cnt_r, fill_cnt_s;
  logic [MW-1:0]    match_cnt_r, match_cnt_s;
  logic [WW-1:0]    win_cnt_r, win_cnt_s;
  logic [LW-1:0]    loss_cnt_r, loss_cnt_s, loss_nxt_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
  logic             locked_r, locked_s;
  logic             error_r, error_s;
  logic             pred_s, mismatch_s, hist_zero_s;
`ifdef LFSR_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
`endif

  assign pred_s      = pred_bit(hist_r);
  assign mismatch_s  = bus.noise_in ^ pred_s;
  // An all-zero history predicts zero forever; never count it as a match.
  assign hist_zero_s = (hist_r == 16'h0000);
  assign loss_nxt_s  = mismatch_s ? (loss_cnt_r + LW'(1)) : loss_cnt_r;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FILL;
      hist_r      <= 16'h0000;
      fill_cnt_r  <= 4'd0;
      match_cnt_r <= {MW{1'b0}};
      win_cnt_r   <= {WW{1'b0}};
      loss_cnt_r  <= {LW{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_r   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      hist_r      <= hist_s;
      fill_cnt_r  <= fill_cnt_s;
      match_cnt_r <= match_cnt_s;
      win_cnt_r   <= win_cnt_s;
      loss_cnt_r  <= loss_cnt_s;
      err_cnt_r   <= err_cnt_s;
      locked_r    <= locked_s;
      error_r     <= error_s;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_r   <= bit_cnt_s;
`endif
    end
  end

  // Next-state and datapath update for one enabled stream bit.
  always_comb begin
    state_s     = state_r;
    hist_s      = hist_r;
    fill_cnt_s  = fill_cnt_r;
    match_cnt_s = match_cnt_r;
    win_cnt_s   = win_cnt_r;
    loss_cnt_s  = loss_cnt_r;
    err_cnt_s   = err_cnt_r;
`ifdef LFSR_CHK_BITCNT_EN
    bit_cnt_s   = bit_cnt_r;
`endif
    if (bus.enable) begin
      case (state_r)
        ST_FILL: begin
          hist_s = {hist_r[14:0], bus.noise_in};
          if (fill_cnt_r == FILL_LAST) begin
            state_s     = ST_VERIFY;
            fill_cnt_s  = 4'd0;
            match_cnt_s = {MW{1'b0}};
          end else begin
            fill_cnt_s = fill_cnt_r + 4'd1;
          end
        end
        ST_VERIFY: begin
          hist_s = {hist_r[14:0], bus.noise_in};
          if (!mismatch_s && !hist_zero_s) begin
            if (match_cnt_r == MATCH_LAST) begin
              state_s     = ST_LOCKED;
              match_cnt_s = {MW{1'b0}};
              win_cnt_s   = {WW{1'b0}};
              loss_cnt_s  = {LW{1'b0}};
            end else begin
              match_cnt_s = match_cnt_r + MW'(1);
            end
          end else begin
            match_cnt_s = {MW{1'b0}};
          end
        end
        ST_LOCKED: begin
          // Flywheel on our own prediction so a bad line bit cannot poison hist.
          hist_s = {hist_r[14:0], pred_s};
          if (mismatch_s) begin
            err_cnt_s = sat_inc(err_cnt_r);
          end else begin
            err_cnt_s = err_cnt_r;
          end
`ifdef LFSR_CHK_BITCNT_EN
          bit_cnt_s = sat_inc(bit_cnt_r);
`endif
          if (loss_nxt_s == LOSS_LIMIT) begin
            state_s    = ST_FILL;
            hist_s     = 16'h0000;
            fill_cnt_s = 4'd0;
            win_cnt_s  = {WW{1'b0}};
            loss_cnt_s = {LW{1'b0}};
          end else if (win_cnt_r == WIN_LAST) begin
            win_cnt_s  = {WW{1'b0}};
            loss_cnt_s = {LW{1'b0}};
          end else begin
            win_cnt_s  = win_cnt_r + WW'(1);
            loss_cnt_s = loss_nxt_s;
          end
        end
        default: begin
          state_s    = ST_FILL;
          hist_s     = 16'h0000;
          fill_cnt_s = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    // Clear overrides any increment made by the same bit.
    if (bus.clear) begin
      err_cnt_s = {CNT_W{1'b0}};
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_s = {CNT_W{1'b0}};
`endif
    end else begin
      err_cnt_s = err_cnt_s;
    end
  end

  // Output decode, registered in the state register block.
  always_comb begin
    locked_s = (state_s == ST_LOCKED);
    if (bus.enable && (state_r == ST_LOCKED) && mismatch_s) begin
      error_s = 1'b1;
    end else begin
      error_s = 1'b0;
    end
  end

  assign bus.locked    = locked_r;
  assign bus.error     = error_r;
  assign bus.err_count = err_cnt_r;
`ifdef LFSR_CHK_BITCNT_EN
  assign bus.bit_count = bit_cnt_r;
`else
  assign bus.bit_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
`timescale 1ns/1ps
module tb_lfsr_checker;
  localparam int CNT_W = 16;
  localparam int MAXC  = 65535;
`ifdef LFSR_CHK_BITCNT_EN
  localparam logic [CNT_W-1:0] BC_CLEAN = 16'd1952;
`else
  localparam logic [CNT_W-1:0] BC_CLEAN = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  lfsr_checker_if #(.CNT_W(CNT_W)) bus_if ();

  lfsr_checker #(.LOCK_COUNT(32), .LOSS_COUNT(8), .LOSS_WIN(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  wire [2*CNT_W+1:0] obs_v = {bus_if.locked, bus_if.error, bus_if.err_count, bus_if.bit_count};

  // Reference model: mode 0=fill 1=verify 2=locked; m_hist[0] is newest bit.
  bit m_hist[$];
  int m_mode, m_fill, m_run, m_win, m_loss, m_err, m_bits;
  bit m_error;
  logic [15:0] g;  // stimulus generator state (last 16 emitted bits)

  function automatic void m_reset();
    m_hist.delete();
    for (int i = 0; i < 16; i++) m_hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_win = 0; m_loss = 0;
    m_err = 0; m_bits = 0; m_error = 1'b0;
  endfunction

  function automatic void m_shift(input bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endfunction

  function automatic void m_step(input bit en, input bit b, input bit clr);
    bit p, zero;
    m_error = 1'b0;
    if (en) begin
      p = m_hist[15] ^ m_hist[14] ^ m_hist[13] ^ m_hist[10];
      zero = 1'b1;
      foreach (m_hist[k]) if (m_hist[k]) zero = 1'b0;
      if (m_mode == 0) begin
        m_shift(b); m_fill++;
        if (m_fill == 16) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        m_run = (b == p && !zero) ? m_run + 1 : 0;
        m_shift(b);
        if (m_run == 32) begin m_mode = 2; m_win = 0; m_loss = 0; end
      end else begin
        m_shift(p);
        if (m_bits < MAXC) m_bits++;
        if (b != p) begin
          m_error = 1'b1;
          if (m_err < MAXC) m_err++;
          m_loss++;
        end
        if (m_loss == 8) begin
          m_mode = 0; m_fill = 0; m_win = 0; m_loss = 0;
          foreach (m_hist[k]) m_hist[k] = 1'b0;
        end else begin
          m_win++;
          if (m_win == 64) begin m_win = 0; m_loss = 0; end
        end
      end
    end
    if (clr) begin m_err = 0; m_bits = 0; end
  endfunction

  function automatic logic [2*CNT_W+1:0] exp_vec();
    logic [CNT_W-1:0] bc;
`ifdef LFSR_CHK_BITCNT_EN
    bc = m_bits[CNT_W-1:0];
`else
    bc = {CNT_W{1'b0}};
`endif
    return {(m_mode == 2), m_error, m_err[CNT_W-1:0], bc};
  endfunction

  function automatic bit gen_bit();
    bit nb;
    nb = g[15] ^ g[14] ^ g[13] ^ g[10];
    g = {g[14:0], nb};
    return nb;
  endfunction

  task automatic step(input bit en, input bit b, input bit clr);
    bus_if.enable = en; bus_if.noise_in = b; bus_if.clear = clr;
    @(posedge clk);
    m_step(en, b, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (3) begin
      bus_if.enable = 1'($urandom); bus_if.noise_in = 1'($urandom); bus_if.clear = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.enable = 1'b0; bus_if.clear = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      bus_if.enable = 1'($urandom); bus_if.noise_in = 1'($urandom); bus_if.clear = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (obs_v !== {(2*CNT_W+2){1'b0}}) begin
        n_fail++; $display("FAIL reset_cyc%0d: got %h expected 0", i, obs_v);
      end
    end
    bus_if.enable = 1'b0; bus_if.clear = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    do_reset(); g = 16'hFFFF;
    for (int i = 1; i <= 2000; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL clean_bit%0d: got %h expected %h", i, obs_v, exp_vec());
      end
      if (i == 47) begin
        n_tests++;
        if (bus_if.locked !== 1'b0) begin n_fail++; $display("FAIL clean_prelock: locked=%b expected 0", bus_if.locked); end
      end
      if (i == 48) begin
        n_tests++;
        if (bus_if.locked !== 1'b1) begin n_fail++; $display("FAIL clean_lock48: locked=%b expected 1", bus_if.locked); end
      end
    end
    n_tests++;
    if (bus_if.err_count !== 16'd0) begin n_fail++; $display("FAIL clean_errcnt: got %0d expected 0", bus_if.err_count); end
    n_tests++;
    if (bus_if.bit_count !== BC_CLEAN) begin n_fail++; $display("FAIL clean_bitcnt: got %0d expected %0d", bus_if.bit_count, BC_CLEAN); end
  endtask

  task automatic test_single_error();
    int pulses;
    bit b;
    do_reset(); g = 16'($urandom_range(1, 65535)); pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      b = gen_bit();
      if (i == 300) b = ~b;
      step(1'b1, b, 1'b0);
      if (bus_if.error === 1'b1) pulses++;
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL single_bit%0d: got %h expected %h", i, obs_v, exp_vec());
      end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    n_tests++;
    if (bus_if.err_count !== 16'd1 || bus_if.locked !== 1'b1) begin
      n_fail++; $display("FAIL single_final: err_count=%0d locked=%b expected 1/1", bus_if.err_count, bus_if.locked);
    end
  endtask

  task automatic test_stuck_low();
    bit seen;
    do_reset(); seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus_if.locked !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL stuck_low: locked seen=1 expected never"); end
  endtask

  task automatic test_stuck_high();
    int pulses;
    do_reset(); g = 16'hFFFF; pulses = 0;
    for (int i = 0; i < 60; i++) step(1'b1, gen_bit(), 1'b0);
    n_tests++;
    if (bus_if.locked !== 1'b1) begin n_fail++; $display("FAIL stuck_high_lock: locked=%b expected 1", bus_if.locked); end
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus_if.error === 1'b1) pulses++;
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL stuck_high_cyc%0d: got %h expected %h", i, obs_v, exp_vec());
      end
    end
    n_tests++;
    if (pulses != 8 || bus_if.locked !== 1'b0) begin
      n_fail++; $display("FAIL stuck_high_final: pulses=%0d locked=%b expected 8/0", pulses, bus_if.locked);
    end
  endtask

  task automatic test_loss_relock();
    bit b;
    do_reset(); g = 16'hFFFF;
    for (int i = 1; i <= 200; i++) begin
      b = gen_bit();
      if (i >= 60 && i <= 67) b = ~b;
      step(1'b1, b, 1'b0);
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL relock_bit%0d: got %h expected %h", i, obs_v, exp_vec());
      end
      if (i == 67 || i == 114) begin
        n_tests++;
        if (bus_if.locked !== 1'b0) begin n_fail++; $display("FAIL relock_drop%0d: locked=%b expected 0", i, bus_if.locked); end
      end
      if (i == 115) begin
        n_tests++;
        if (bus_if.locked !== 1'b1) begin n_fail++; $display("FAIL relock_rise: locked=%b expected 1", bus_if.locked); end
      end
    end
    n_tests++;
    if (bus_if.err_count !== 16'd8) begin n_fail++; $display("FAIL relock_errcnt: got %0d expected 8", bus_if.err_count); end
  endtask

  task automatic test_seven_errors();
    logic [63:0] mask;
    int c, o;
    bit b;
    do_reset(); g = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 48; i++) step(1'b1, gen_bit(), 1'b0);
    for (int w = 0; w < 5; w++) begin
      mask = 64'd0; c = 0;
      while (c < 7) begin
        o = $urandom_range(0, 63);
        if (!mask[o]) begin mask[o] = 1'b1; c++; end
      end
      for (int k = 0; k < 64; k++) begin
        b = gen_bit();
        if (mask[k]) b = ~b;
        step(1'b1, b, 1'b0);
        n_tests++;
        if (obs_v !== exp_vec()) begin
          n_fail++; $display("FAIL seven_w%0d_b%0d: got %h expected %h", w, k, obs_v, exp_vec());
        end
      end
    end
    n_tests++;
    if (bus_if.locked !== 1'b1 || bus_if.err_count !== 16'd35) begin
      n_fail++; $display("FAIL seven_final: locked=%b err_count=%0d expected 1/35", bus_if.locked, bus_if.err_count);
    end
  endtask

  task automatic test_gapped_enable();
    do_reset(); g = 16'($urandom_range(1, 65535));
    for (int k = 1; k <= 48; k++) begin
      step(1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, gen_bit(), 1'b0);
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL gapped_bit%0d: got %h expected %h", k, obs_v, exp_vec());
      end
      if (k == 47 || k == 48) begin
        n_tests++;
        if (bus_if.locked !== (k == 48)) begin
          n_fail++; $display("FAIL gapped_lock%0d: locked=%b expected %0d", k, bus_if.locked, (k == 48));
        end
      end
    end
  endtask

  task automatic test_clear_mismatch();
    step(1'b1, ~gen_bit(), 1'b0);
    n_tests++;
    if (bus_if.err_count !== 16'd1) begin n_fail++; $display("FAIL clr_pre: err_count=%0d expected 1", bus_if.err_count); end
    step(1'b1, ~gen_bit(), 1'b1);
    n_tests++;
    if (bus_if.error !== 1'b1 || bus_if.err_count !== 16'd0) begin
      n_fail++; $display("FAIL clr_mismatch: error=%b err_count=%0d expected 1/0", bus_if.error, bus_if.err_count);
    end
    step(1'b1, ~gen_bit(), 1'b0);
    step(1'b0, 1'($urandom), 1'b1);
    n_tests++;
    if (obs_v !== exp_vec() || bus_if.err_count !== 16'd0 || bus_if.locked !== 1'b1) begin
      n_fail++; $display("FAIL clr_idle: got %h expected %h", obs_v, exp_vec());
    end
  endtask

  task automatic test_reset_while_locked();
    n_tests++;
    if (bus_if.locked !== 1'b1) begin n_fail++; $display("FAIL rst_pre: locked=%b expected 1", bus_if.locked); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_v !== {(2*CNT_W+2){1'b0}}) begin n_fail++; $display("FAIL rst_async: got %h expected 0", obs_v); end
    do_reset();
    for (int i = 1; i <= 48; i++) step(1'b1, gen_bit(), 1'b0);
    n_tests++;
    if (obs_v !== exp_vec() || bus_if.locked !== 1'b1) begin
      n_fail++; $display("FAIL rst_relock: got %h expected %h", obs_v, exp_vec());
    end
  endtask

  task automatic test_random();
    bit en, b, clr;
    do_reset(); g = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      b   = en ? gen_bit() : 1'($urandom);
      if (en && $urandom_range(0, 39) == 0) b = ~b;
      clr = ($urandom_range(0, 99) == 0);
      step(en, b, clr);
      n_tests++;
      if (obs_v !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", i, obs_v, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.enable = 1'b0; bus_if.noise_in = 1'b0; bus_if.clear = 1'b0;
    g = 16'hFFFF;
    m_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_stuck_low();
    test_stuck_high();
    test_loss_relock();
    test_seven_errors();
    test_gapped_enable();
    test_clear_mismatch();
    test_reset_while_locked();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
